// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and default bit timing.
package uart_pkg;

    // 100 MHz clock at 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, a valid/ready output register,
// a one-cycle framing-error pulse and a sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    uart_state_e          state_q;
    logic [CntW-1:0]      cnt_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    // Synchronizer flops reset to the idle (high) line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfEnd) begin
                        cnt_q   <= '0;
                        state_q <= rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitEnd) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BitEnd) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= StIdle;
                            // A same-cycle acceptance frees the register for the new byte
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            state_q     <= StBreak;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StBreak: begin
                    if (rx_s_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 8 clocks per bit: stimulus queues expected bytes,
// a negedge monitor pops and compares on every accepted rx_data.
module tb_uart_rx;

    localparam int unsigned CPB = 8;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int checks;
    int errors;
    int fe_count;
    int accept_count;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard queue
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_count++;
            if (rx_valid && rx_ready) begin
                accept_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %0h, expected none", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL rx_data: got %0h, expected %0h", rx_data, e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fe0;
        int acc0;
        logic [7:0] b;
        checks = 0;
        errors = 0;
        fe_count = 0;
        accept_count = 0;
        reset = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        tick(5);

        // Single good frame
        acc0 = accept_count;
        exp_q.push_back(8'hC0);
        send_frame(8'hC0, 1'b1);
        rx = 1'b1;
        wait_drain("c0_drain", 50);
        tick(10);
        check("c0_accepts", accept_count - acc0, 1);
        check("c0_frame_err", fe_count, 0);
        check("c0_overrun", overrun, 0);

        // Short low glitch must be rejected silently
        acc0 = accept_count;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        check("glitch_accepts", accept_count - acc0, 0);
        check("glitch_frame_err", fe_count, 0);
        check("glitch_overrun", overrun, 0);

        // Bad stop bit followed by a held-low line, then a good frame
        fe0 = fe_count;
        acc0 = accept_count;
        send_frame(8'hF5, 1'b0);
        tick(20);
        rx = 1'b1;
        tick(16);
        check("break_frame_err", fe_count - fe0, 1);
        check("break_no_valid", accept_count - acc0, 0);
        exp_q.push_back(8'h2A);
        send_frame(8'h2A, 1'b1);
        rx = 1'b1;
        wait_drain("after_break_drain", 50);
        check("after_break_fe", fe_count - fe0, 1);

        // Overrun: consumer stalled across two back-to-back frames
        rx_ready = 1'b0;
        exp_q.push_back(8'hC0);
        send_frame(8'hC0, 1'b1);
        send_frame(8'hF5, 1'b1);
        rx = 1'b1;
        tick(20);
        check("ovr_rx_valid", rx_valid, 1);
        check("ovr_rx_data", rx_data, 8'hC0);
        check("ovr_overrun", overrun, 1);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_valid_clear", rx_valid, 0);
        check("ovr_sticky", overrun, 1);
        wait_drain("ovr_drain", 10);

        // Reset in the middle of bit 4 of 8'h5A
        fe0 = fe_count;
        b = 8'h5A;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = b[4];
        tick(3);
        reset = 1'b1;
        tick(1);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        rx = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(10);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        rx = 1'b1;
        wait_drain("midrst_drain", 50);
        check("midrst_after_fe", fe_count - fe0, 0);
        check("midrst_after_ovr", overrun, 0);

        // Back-to-back stream 0x00, 0x35, ... 0xFF with no idle gap
        fe0 = fe_count;
        acc0 = accept_count;
        b = 8'h00;
        begin
            int n;
            n = 0;
            forever begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
                n++;
                if (b == 8'hFF) break;
                b = b + 8'd53;
            end
            rx = 1'b1;
            wait_drain("stream_drain", 50);
            tick(10);
            check("stream_count", accept_count - acc0, n);
            check("stream_count_exact", n, 228);
        end
        check("stream_frame_err", fe_count - fe0, 0);
        check("stream_overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  serial line, idle high, 8N1 framing, LSB first; asynchronous to clk.
REQ-005 rx_data  output  8  last correctly framed byte.
REQ-006 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  sticky: byte completed while rx_valid high and not accepted.

Function
REQ-010 rx SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (rx_s), adding 2 cycles latency.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: rx_s low -> START, bit counter cleared, cycle counter cleared.
REQ-013 START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s; low -> DATA, high -> IDLE (glitch rejected, no flag).
REQ-014 DATA: sample rx_s every CLKS_PER_BIT cycles into shift register LSB first; after 8th sample -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles sample rx_s; high -> IDLE with byte delivered, low -> BREAK with frame_err pulsed one cycle, byte discarded.
REQ-016 BREAK: remain until rx_s high, then IDLE; no start detection while in BREAK.
REQ-017 Delivery: rx_data loaded and rx_valid set on cycle after the stop-bit sample.
REQ-018 rx_valid SHALL clear on the cycle after rx_valid and rx_ready both high; rx_data unchanged until next delivery.
REQ-019 Delivery while rx_valid high and rx_ready low: new byte dropped, rx_data keeps old byte, overrun set.
REQ-020 Delivery in same cycle as acceptance (rx_valid and rx_ready high): new byte loaded, rx_valid stays high, no overrun.
REQ-021 overrun SHALL clear only on reset.
REQ-022 Cycle counter width SHALL be $clog2(CLKS_PER_BIT)+1 bits; no wrap within a bit period.
REQ-023 Receiver SHALL re-arm in IDLE immediately after a good stop sample, supporting back-to-back frames with zero extra idle.

Reset
REQ-024 Reset SHALL force: state IDLE, counters 0, shift register 0, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, synchronizer flops 1 (idle).
REQ-025 Reset mid-frame SHALL abandon the frame with no flag; first complete frame after deassertion SHALL be received correctly.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state encoding and default CLKS_PER_BIT, also used by the matching transmitter.
REQ-027 No sub-module; synchronizer, FSM, and output register stay in uart_rx.

Verification (CLKS_PER_BIT = 8, rx_ready held high unless stated)
REQ-028 Send 8'hC0 framed -> rx_valid one cycle, rx_data 8'hC0, frame_err 0, overrun 0.
REQ-029 Drive rx low 3 cycles then high -> FSM returns to IDLE, rx_valid never asserts, no flags.
REQ-030 Send 8'hF5 with stop bit low, line low 20 more cycles -> frame_err one pulse, no rx_valid; a following 8'h2A received after line returns high.
REQ-031 rx_ready low, send 8'hC0 then 8'hF5 back-to-back -> rx_data 8'hC0, rx_valid high, overrun 1; raise rx_ready -> rx_valid clears next cycle.
REQ-032 Assert reset during bit 4 of 8'h5A -> all outputs zero; after release send 8'h5A -> rx_data 8'h5A, no flags.
REQ-033 Stream 0x00,0x35,...,0xFF (step 53 modulo 256) with zero idle gap -> every byte delivered in order, no flags.
